// File: rtl/vec_alu_seq_pkg.sv
// Shared encodings for the vector ALU sequencer: op types, completion codes,
// FSM states, SEW decode and the latched request record.
package vec_alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_VV = 3'b001,
    OP_VX = 3'b010,
    OP_VI = 3'b100
  } op_type_e;

  typedef enum logic [1:0] {
    CMP_OK       = 2'b00,
    CMP_ILL_VSEW = 2'b01,
    CMP_TIMEOUT  = 2'b10
  } cmp_err_e;

  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_RD2, S_CAP, S_RUN, S_WB, S_ERR
  } state_e;

  localparam logic [2:0] SEW_8   = 3'd0;
  localparam logic [2:0] SEW_16  = 3'd1;
  localparam logic [2:0] SEW_32  = 3'd2;
  localparam logic [2:0] SEW_64  = 3'd3;
  localparam logic [2:0] SEW_MAX = SEW_64;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [2:0]  op_type;
    logic [2:0]  vsew;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [4:0]  vd;
    logic [31:0] scalar;
    logic [4:0]  imm;
  } req_t;

  // Mask selecting the byte position inside one element (element bytes - 1).
  function automatic logic [2:0] sew_byte_mask(input logic [2:0] vsew);
    case (vsew)
      SEW_8:   return 3'd0;
      SEW_16:  return 3'd1;
      SEW_32:  return 3'd3;
      SEW_64:  return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vec_alu_seq_bcast.sv
// vec_bcast: replicates the low SEW bits of a 64-bit value across VLEN.
module vec_bcast
  import vec_alu_seq_pkg::*;
#(
  parameter int unsigned VLEN = 128
) (
  input  logic [63:0]     val_i,
  input  logic [2:0]      vsew_i,
  output logic [VLEN-1:0] vec_o
);

  logic [2:0] mask;
  logic [2:0] sel;

  // Byte b of the vector takes byte (b mod element-bytes) of the value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    vec_o = '0;
    sel   = '0;
    mask  = sew_byte_mask(vsew_i);
    for (int b = 0; b < int'(VLEN / 8); b++) begin
      sel = 3'(b) & mask;
      vec_o[b*8 +: 8] = val_i[{sel, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/vec_alu_seq.sv
// Sequencer for one vector ALU instruction: reads two VRF operands, drives
// the external lanes until all report done, then OR-merges and writes back.
module vec_alu_seq
  import vec_alu_seq_pkg::*;
#(
  parameter int unsigned VLEN    = 10'd128,
  parameter int unsigned NL_LOG2 = 2'd2,
  parameter int unsigned TIMEOUT = 8'd255
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [5:0]                      req_opcode,
  input  logic [2:0]                      req_op_type,
  input  logic [2:0]                      req_vsew,
  input  logic [4:0]                      req_vs1,
  input  logic [4:0]                      req_vs2,
  input  logic [4:0]                      req_vd,
  input  logic [31:0]                     req_scalar,
  input  logic [4:0]                      req_imm,
  output logic [4:0]                      vrf_raddr,
  input  logic [VLEN-1:0]                 vrf_rdata,
  output logic                            vrf_we,
  output logic [4:0]                      vrf_waddr,
  output logic [VLEN-1:0]                 vrf_wdata,
  output logic                            lane_run,
  output logic [5:0]                      lane_opcode,
  output logic [2:0]                      lane_vsew,
  output logic [2:0]                      lane_op_type,
  output logic [1:0]                      lane_nb_lanes,
  output logic [VLEN-1:0]                 lane_vs1,
  output logic [VLEN-1:0]                 lane_vs2,
  input  logic [(1<<NL_LOG2)-1:0]         lane_done,
  input  logic [(1<<NL_LOG2)*VLEN-1:0]    lane_vd,
  output logic                            cmp_valid,
  output logic [1:0]                      cmp_err
);

  localparam int unsigned NL         = 1 << NL_LOG2;
  localparam logic [7:0]  TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  cmp_err_e        err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [VLEN-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [VLEN-1:0] bcast_vec, merged;
  logic [63:0]     bcast_val;
  logic            all_done, use_bcast;

  assign all_done  = &lane_done;
  assign use_bcast = (req_q.op_type == OP_VX) || (req_q.op_type == OP_VI);

  // Sign-extended to 64 bits, so the low SEW bits are correct for every SEW.
  always_comb begin
    bcast_val = {{32{req_q.scalar[31]}}, req_q.scalar};
    if (req_q.op_type == OP_VI) bcast_val = {{59{req_q.imm[4]}}, req_q.imm};
  end

  vec_bcast #(.VLEN(VLEN)) u_bcast (
    .val_i  (bcast_val),
    .vsew_i (req_q.vsew),
    .vec_o  (bcast_vec)
  );

  always_comb begin
    merged = '0;
    for (int k = 0; k < int'(NL); k++) merged = merged | lane_vd[k*VLEN +: VLEN];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = (req_vsew > SEW_MAX) ? S_ERR : S_RD1;
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = S_CAP;
      S_CAP:   state_d = S_RUN;
      S_RUN: begin
        if (all_done)                 state_d = S_WB;
        else if (cnt_q == TIMEOUT_M1) state_d = S_ERR;
      end
      S_WB, S_ERR: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;
    err_d = err_q;
    op1_d = op1_q;
    op2_d = op2_q;
    cnt_d = '0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        req_d = '{opcode: req_opcode, op_type: req_op_type, vsew: req_vsew,
                  vs1: req_vs1, vs2: req_vs2, vd: req_vd,
                  scalar: req_scalar, imm: req_imm};
        err_d = (req_vsew > SEW_MAX) ? CMP_ILL_VSEW : CMP_OK;
      end
      S_RD2: op1_d = use_bcast ? bcast_vec : vrf_rdata;
      S_CAP: op2_d = vrf_rdata;
      S_RUN: begin
        cnt_d = cnt_q + 8'd1;
        if (!all_done && cnt_q == TIMEOUT_M1) err_d = CMP_TIMEOUT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_q <= '0;
      err_q <= CMP_OK;
      cnt_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
    end else begin
      req_q <= req_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
    end
  end

  // Outputs decode from state only; anything not named for a state stays 0.
  always_comb begin
    req_ready     = 1'b0;
    vrf_raddr     = '0;
    vrf_we        = 1'b0;
    vrf_waddr     = '0;
    vrf_wdata     = '0;
    lane_run      = 1'b0;
    lane_opcode   = '0;
    lane_vsew     = '0;
    lane_op_type  = '0;
    lane_nb_lanes = '0;
    lane_vs1      = '0;
    lane_vs2      = '0;
    cmp_valid     = 1'b0;
    cmp_err       = CMP_OK;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_RD1:  vrf_raddr = req_q.vs1;
      S_RD2:  vrf_raddr = req_q.vs2;
      S_RUN: begin
        lane_run      = 1'b1;
        lane_opcode   = req_q.opcode;
        lane_vsew     = req_q.vsew;
        lane_op_type  = req_q.op_type;
        lane_nb_lanes = 2'(NL_LOG2);
        lane_vs1      = op1_q;
        lane_vs2      = op2_q;
      end
      S_WB: begin
        vrf_we    = 1'b1;
        vrf_waddr = req_q.vd;
        vrf_wdata = merged;
        cmp_valid = 1'b1;
      end
      S_ERR: begin
        cmp_valid = 1'b1;
        cmp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vec_alu_seq.sv
// Directed bench for vec_alu_seq with a VRF model and a simple four-lane
// model that ANDs its quarter of the operands and can hold one lane stuck.
module tb_vec_alu_seq;
  import vec_alu_seq_pkg::*;

  localparam int VLEN = 128, NL_LOG2 = 2, NL = 4, LW = VLEN / NL;
  localparam int TIMEOUT = 16, LANE_LAT = 3;
  localparam logic [5:0] VAND = 6'b001001;

  logic clk = 1'b0, resetn = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [5:0] req_opcode = '0;
  logic [2:0] req_op_type = '0, req_vsew = '0;
  logic [4:0] req_vs1 = '0, req_vs2 = '0, req_vd = '0, req_imm = '0;
  logic [31:0] req_scalar = '0;
  logic [4:0] vrf_raddr, vrf_waddr;
  logic [VLEN-1:0] vrf_rdata = '0, vrf_wdata, lane_vs1, lane_vs2;
  logic vrf_we, lane_run, cmp_valid;
  logic [5:0] lane_opcode;
  logic [2:0] lane_vsew, lane_op_type;
  logic [1:0] lane_nb_lanes, cmp_err;
  logic [NL-1:0] lane_done = '0, stuck = '0;
  logic [NL*VLEN-1:0] lane_vd = '0;
  logic [7:0] rc = '0;

  vec_alu_seq #(.VLEN(VLEN), .NL_LOG2(NL_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op_type(req_op_type), .req_vsew(req_vsew),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vd(req_vd),
    .req_scalar(req_scalar), .req_imm(req_imm),
    .vrf_raddr(vrf_raddr), .vrf_rdata(vrf_rdata),
    .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
    .lane_run(lane_run), .lane_opcode(lane_opcode), .lane_vsew(lane_vsew),
    .lane_op_type(lane_op_type), .lane_nb_lanes(lane_nb_lanes),
    .lane_vs1(lane_vs1), .lane_vs2(lane_vs2),
    .lane_done(lane_done), .lane_vd(lane_vd),
    .cmp_valid(cmp_valid), .cmp_err(cmp_err)
  );

  always #5 clk = ~clk;

  logic [VLEN-1:0] vrf [32];
  always @(posedge clk) vrf_rdata <= vrf[vrf_raddr];

  // Lane k returns its own LW-bit slice of vs1 & vs2; lane_vd clears while run is low.
  wire [VLEN-1:0] lane_res = lane_vs1 & lane_vs2;
  always @(posedge clk) begin
    if (lane_run) begin
      rc <= rc + 8'd1;
      for (int k = 0; k < NL; k++)
        if (int'(rc) + 1 >= LANE_LAT && !stuck[k]) begin
          lane_done[k] <= 1'b1;
          lane_vd[k*VLEN + k*LW +: LW] <= lane_res[k*LW +: LW];
        end
    end else begin
      rc        <= '0;
      lane_done <= '0;
      lane_vd   <= '0;
    end
  end

  int n_cmp = 0, n_bad = 0;

  int o_first_run, o_run, o_we, o_cmp, o_cmp_cyc, o_ready_bad, o_stable_bad;
  logic [1:0] o_err, o_nb;
  logic [4:0] o_waddr;
  logic [VLEN-1:0] o_vs1, o_vs2, o_wdata;
  logic [2:0] o_vsew, o_opt;
  logic [5:0] o_opc;
  logic o_cmp_after, o_ready_after;

  function automatic req_t mk(input logic [2:0] op_type, input logic [2:0] vsew,
                              input logic [4:0] vs1, input logic [4:0] vs2,
                              input logic [4:0] vd, input logic [31:0] scalar,
                              input logic [4:0] imm);
    req_t r;
    r = '{opcode: VAND, op_type: op_type, vsew: vsew, vs1: vs1, vs2: vs2,
          vd: vd, scalar: scalar, imm: imm};
    return r;
  endfunction

  task automatic set_req(input req_t r);
    req_opcode = r.opcode; req_op_type = r.op_type; req_vsew = r.vsew;
    req_vs1 = r.vs1; req_vs2 = r.vs2; req_vd = r.vd;
    req_scalar = r.scalar; req_imm = r.imm;
    req_valid = 1'b1;
  endtask

  // Entered at a sample point in IDLE with req_valid high; cycle c counts from acceptance.
  task automatic run_op(input int budget, input bit hold, input req_t nxt);
    o_first_run = -1; o_run = 0; o_we = 0; o_cmp = 0; o_cmp_cyc = -1;
    o_ready_bad = 0; o_stable_bad = 0; o_err = 2'b11; o_waddr = '0;
    o_wdata = '0; o_vs1 = '0; o_vs2 = '0; o_nb = '0; o_vsew = '0; o_opt = '0; o_opc = '0;
    @(posedge clk); #1;
    if (hold) set_req(nxt); else req_valid = 1'b0;
    for (int c = 1; c <= budget && o_cmp == 0; c++) begin
      if (lane_run) begin
        if (o_first_run < 0) begin
          o_first_run = c; o_vs1 = lane_vs1; o_vs2 = lane_vs2; o_nb = lane_nb_lanes;
          o_vsew = lane_vsew; o_opt = lane_op_type; o_opc = lane_opcode;
        end else if (lane_vs1 !== o_vs1 || lane_vs2 !== o_vs2) o_stable_bad++;
        o_run++;
      end
      if (vrf_we) begin o_we++; o_waddr = vrf_waddr; o_wdata = vrf_wdata; end
      if (cmp_valid) begin o_cmp++; o_cmp_cyc = c; o_err = cmp_err; end
      if (req_ready) o_ready_bad++;
      @(posedge clk); #1;
    end
    o_cmp_after = cmp_valid;
    o_ready_after = req_ready;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_cmp++; if ({vrf_we, lane_run, cmp_valid, cmp_err} !== 5'b0) begin n_bad++; $display("FAIL rst_ctrl: got %b want 0", {vrf_we, lane_run, cmp_valid, cmp_err}); end
    n_cmp++; if ({vrf_waddr, vrf_wdata, vrf_raddr} !== '0) begin n_bad++; $display("FAIL rst_vrf: got %h want 0", {vrf_waddr, vrf_wdata, vrf_raddr}); end
    n_cmp++; if ({lane_opcode, lane_vsew, lane_op_type, lane_nb_lanes, lane_vs1, lane_vs2} !== '0) begin n_bad++; $display("FAIL rst_lane: got %h want 0", {lane_opcode, lane_vsew, lane_op_type, lane_nb_lanes, lane_vs1, lane_vs2}); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vv();
    set_req(mk(OP_VV, SEW_8, 5'd1, 5'd2, 5'd10, 32'h0, 5'h0));
    run_op(40, 1'b0, '0);
    n_cmp++; if (o_first_run !== 4) begin n_bad++; $display("FAIL vv_run_start: got %0d want 4", o_first_run); end
    n_cmp++; if (o_run !== 4) begin n_bad++; $display("FAIL vv_run_cycles: got %0d want 4", o_run); end
    n_cmp++; if (o_cmp !== 1 || o_cmp_cyc !== 8) begin n_bad++; $display("FAIL vv_cmp: got %0d at %0d want 1 at 8", o_cmp, o_cmp_cyc); end
    n_cmp++; if (o_err !== 2'b00) begin n_bad++; $display("FAIL vv_err: got %b want 00", o_err); end
    n_cmp++; if (o_we !== 1 || o_waddr !== 5'd10) begin n_bad++; $display("FAIL vv_waddr: got %0d writes to %0d want 1 to 10", o_we, o_waddr); end
    n_cmp++; if (o_wdata !== {8{16'h0F00}}) begin n_bad++; $display("FAIL vv_wdata: got %h want %h", o_wdata, {8{16'h0F00}}); end
    n_cmp++; if (o_vs1 !== {8{16'hFF00}} || o_vs2 !== {16{8'h0F}}) begin n_bad++; $display("FAIL vv_operands: got %h %h", o_vs1, o_vs2); end
    n_cmp++; if ({o_opc, o_opt, o_vsew, o_nb} !== {VAND, 3'b001, 3'd0, 2'd2}) begin n_bad++; $display("FAIL vv_lane_ctrl: got %h want %h", {o_opc, o_opt, o_vsew, o_nb}, {VAND, 3'b001, 3'd0, 2'd2}); end
    n_cmp++; if (o_stable_bad !== 0 || o_ready_bad !== 0) begin n_bad++; $display("FAIL vv_stable_busy: got %0d/%0d want 0/0", o_stable_bad, o_ready_bad); end
    n_cmp++; if (o_cmp_after !== 1'b0 || o_ready_after !== 1'b1) begin n_bad++; $display("FAIL vv_pulse: got cmp %b ready %b want 0 1", o_cmp_after, o_ready_after); end
  endtask

  task automatic test_vx();
    set_req(mk(OP_VX, SEW_16, 5'd7, 5'd4, 5'd11, 32'h0001ABCD, 5'h0));
    run_op(40, 1'b0, '0);
    n_cmp++; if (o_vs1 !== {8{16'hABCD}}) begin n_bad++; $display("FAIL vx16_vs1: got %h want %h", o_vs1, {8{16'hABCD}}); end
    n_cmp++; if (o_wdata !== {8{16'hABCD}} || o_waddr !== 5'd11) begin n_bad++; $display("FAIL vx16_wb: got %h @%0d", o_wdata, o_waddr); end
    n_cmp++; if (o_cmp_cyc !== 8 || o_opt !== 3'b010 || o_vsew !== 3'd1) begin n_bad++; $display("FAIL vx16_timing: got %0d %b %0d want 8 010 1", o_cmp_cyc, o_opt, o_vsew); end
    set_req(mk(OP_VX, SEW_64, 5'd7, 5'd4, 5'd11, 32'h80000001, 5'h0));
    run_op(40, 1'b0, '0);
    n_cmp++; if (o_vs1 !== {2{64'hFFFFFFFF80000001}}) begin n_bad++; $display("FAIL vx64_vs1: got %h want %h", o_vs1, {2{64'hFFFFFFFF80000001}}); end
  endtask

  task automatic test_vi();
    set_req(mk(OP_VI, SEW_32, 5'd7, 5'd2, 5'd12, 32'hDEADBEEF, 5'b10000));
    run_op(40, 1'b0, '0);
    n_cmp++; if (o_vs1 !== {4{32'hFFFFFFF0}}) begin n_bad++; $display("FAIL vi_vs1: got %h want %h", o_vs1, {4{32'hFFFFFFF0}}); end
    n_cmp++; if (o_first_run !== 4) begin n_bad++; $display("FAIL vi_run_start: got %0d want 4", o_first_run); end
    n_cmp++; if (o_wdata !== {4{32'h0F0F0F00}}) begin n_bad++; $display("FAIL vi_wdata: got %h want %h", o_wdata, {4{32'h0F0F0F00}}); end
  endtask

  task automatic test_illegal_vsew();
    set_req(mk(OP_VV, 3'b101, 5'd1, 5'd2, 5'd13, 32'h0, 5'h0));
    run_op(20, 1'b0, '0);
    n_cmp++; if (o_cmp !== 1 || o_cmp_cyc !== 1) begin n_bad++; $display("FAIL ill_cmp: got %0d at %0d want 1 at 1", o_cmp, o_cmp_cyc); end
    n_cmp++; if (o_err !== 2'b01) begin n_bad++; $display("FAIL ill_err: got %b want 01", o_err); end
    n_cmp++; if (o_run !== 0 || o_we !== 0) begin n_bad++; $display("FAIL ill_side: got run %0d we %0d want 0 0", o_run, o_we); end
    n_cmp++; if (o_cmp_after !== 1'b0 || o_ready_after !== 1'b1) begin n_bad++; $display("FAIL ill_pulse: got cmp %b ready %b want 0 1", o_cmp_after, o_ready_after); end
  endtask

  task automatic test_timeout();
    stuck = 4'b0100;
    set_req(mk(OP_VV, SEW_8, 5'd1, 5'd2, 5'd14, 32'h0, 5'h0));
    run_op(60, 1'b0, '0);
    stuck = '0;
    n_cmp++; if (o_run !== TIMEOUT) begin n_bad++; $display("FAIL to_run_cycles: got %0d want %0d", o_run, TIMEOUT); end
    n_cmp++; if (o_cmp !== 1 || o_cmp_cyc !== 20) begin n_bad++; $display("FAIL to_cmp: got %0d at %0d want 1 at 20", o_cmp, o_cmp_cyc); end
    n_cmp++; if (o_err !== 2'b10 || o_we !== 0) begin n_bad++; $display("FAIL to_err: got %b we %0d want 10 0", o_err, o_we); end
    n_cmp++; if (o_ready_after !== 1'b1 || lane_run !== 1'b0) begin n_bad++; $display("FAIL to_after: got ready %b run %b want 1 0", o_ready_after, lane_run); end
    set_req(mk(OP_VV, SEW_8, 5'd1, 5'd2, 5'd15, 32'h0, 5'h0));
    run_op(40, 1'b0, '0);
    n_cmp++; if (o_err !== 2'b00 || o_cmp_cyc !== 8 || o_wdata !== {8{16'h0F00}}) begin n_bad++; $display("FAIL to_next: got %b at %0d data %h", o_err, o_cmp_cyc, o_wdata); end
  endtask

  task automatic test_back_to_back();
    set_req(mk(OP_VV, SEW_8, 5'd1, 5'd2, 5'd16, 32'h0, 5'h0));
    run_op(40, 1'b1, mk(OP_VV, SEW_8, 5'd4, 5'd2, 5'd4, 32'h0, 5'h0));
    n_cmp++; if (o_wdata !== {8{16'h0F00}} || o_waddr !== 5'd16) begin n_bad++; $display("FAIL b2b_first: got %h @%0d", o_wdata, o_waddr); end
    n_cmp++; if (o_ready_bad !== 0 || o_ready_after !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got busy-ready %0d after %b want 0 1", o_ready_bad, o_ready_after); end
    run_op(40, 1'b0, '0);
    n_cmp++; if (o_cmp_cyc !== 8 || o_wdata !== {16{8'h0F}} || o_waddr !== 5'd4) begin n_bad++; $display("FAIL b2b_second: got %h @%0d at %0d", o_wdata, o_waddr, o_cmp_cyc); end
  endtask

  task automatic test_reset_mid_run();
    int bad = 0;
    set_req(mk(OP_VV, SEW_8, 5'd1, 5'd2, 5'd17, 32'h0, 5'h0));
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++; if (lane_run !== 1'b1) begin n_bad++; $display("FAIL rmid_running: got %b want 1", lane_run); end
    resetn = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (lane_run !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_drop: got run %b ready %b want 0 1", lane_run, req_ready); end
    repeat (2) begin if (vrf_we || cmp_valid) bad++; @(posedge clk); #1; end
    resetn = 1'b1;
    repeat (8) begin if (vrf_we || cmp_valid || lane_run) bad++; @(posedge clk); #1; end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rmid_quiet: got %0d stray cycles want 0", bad); end
    set_req(mk(OP_VX, SEW_8, 5'd7, 5'd4, 5'd18, 32'h0000005A, 5'h0));
    run_op(40, 1'b0, '0);
    n_cmp++; if (o_cmp !== 1 || o_err !== 2'b00 || o_wdata !== {16{8'h5A}} || o_waddr !== 5'd18) begin n_bad++; $display("FAIL rmid_second: got %0d %b %h @%0d", o_cmp, o_err, o_wdata, o_waddr); end
    n_cmp++; if (o_ready_bad !== 0) begin n_bad++; $display("FAIL rmid_busy_ready: got %0d want 0", o_ready_bad); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) vrf[i] = '0;
    vrf[1] = {8{16'hFF00}};
    vrf[2] = {16{8'h0F}};
    vrf[4] = '1;
    vrf[7] = {4{32'h12345678}};
    test_reset();
    test_vv();
    test_vx();
    test_vi();
    test_illegal_vsew();
    test_timeout();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_alu_seq.md
VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

Interface
REQ-001 Parameters: VLEN, default 10'd128, vector register width in bits; NL_LOG2, default 2'd2, log2 of ALU lane count (NL = 1<<NL_LOG2); TIMEOUT, default 8'd255, maximum RUN cycles.
REQ-002 Clock and reset: clk in 1, rising-edge clock; resetn in 1, synchronous, active-low reset.
REQ-003 Request: req_valid in 1; req_ready out 1; req_opcode in 6; req_op_type in 3 (001 VV, 010 VX, 100 VI); req_vsew in 3; req_vs1 in 5; req_vs2 in 5; req_vd in 5; req_scalar in 32; req_imm in 5.
REQ-004 VRF read: vrf_raddr out 5; vrf_rdata in VLEN. Read data is valid one cycle after the address.
REQ-005 VRF write: vrf_we out 1; vrf_waddr out 5; vrf_wdata out VLEN.
REQ-006 Lane drive: lane_run out 1; lane_opcode out 6; lane_vsew out 3; lane_op_type out 3; lane_nb_lanes out 2 (= NL_LOG2); lane_vs1 out VLEN; lane_vs2 out VLEN.
REQ-007 Lane return: lane_done in NL; lane_vd in NL*VLEN (lane k at bits [k*VLEN +: VLEN]).
REQ-008 Completion: cmp_valid out 1, one-cycle pulse; cmp_err out 2 (00 ok, 01 illegal vsew, 10 timeout).

Function
REQ-009 States: IDLE, RD1, RD2, CAP, RUN, WB, ERR.
REQ-010 IDLE: req_ready=1. On req_valid, latch all req_* fields and go to RD1. No other state asserts req_ready.
REQ-011 If latched vsew>3, go from IDLE directly to ERR; ERR asserts cmp_valid=1 with cmp_err=01, writes no VRF entry, drives no lane_run, and returns to IDLE.
REQ-012 RD1: vrf_raddr=vs1. RD2: capture vrf_rdata into the op1 register and set vrf_raddr=vs2. CAP: capture vrf_rdata into the op2 register. Then go to RUN.
REQ-013 For VX, op1 = req_scalar low SEW bits replicated across VLEN. For SEW=64, the scalar is sign-extended to 64 bits.
REQ-014 For VI, op1 = req_imm sign-extended to SEW and replicated across VLEN.
REQ-015 For VX and VI, the RD1 read still occurs and its data is discarded. Latency is therefore mode-independent.
REQ-016 RUN: lane_run=1, and lane_opcode/vsew/op_type/vs1/vs2 are held stable from the latched values. A cycle counter starts at 0.
REQ-017 RUN exit: when all NL bits of lane_done are sampled 1, go to WB on the next edge.
REQ-018 Timeout: if the counter reaches TIMEOUT before all lanes are done, go to ERR with cmp_err=10, write no VRF entry, and drop lane_run.
REQ-019 WB, lasting one cycle: lane_run=0; vrf_we=1; vrf_waddr=vd; vrf_wdata = bitwise OR of all NL lane_vd slices; cmp_valid=1; cmp_err=00. Then go to IDLE.
REQ-020 Lanes clear lane_vd while run is low, so the OR-merge is exact.
REQ-021 Latency: acceptance in cycle T gives RD1 at T+1, lane_run first high at T+4, and WB one cycle after all-done is sampled.
REQ-022 Back-to-back: a new req_valid is accepted the cycle after WB or ERR.
REQ-023 A request presented while busy stays pending and is not latched.
REQ-024 vs1, vs2 and vd may alias. The source operands are captured before WB.

Reset
REQ-025 While resetn=0 at a clk edge, state=IDLE; all outputs except req_ready are 0, including vrf_we, lane_run, cmp_valid, cmp_err, vrf_waddr, vrf_wdata and the lane_* buses; req_ready=1.
REQ-026 The op1/op2 registers and the counter clear on reset.
REQ-027 Reset mid-operation, in any state, abandons the instruction with no VRF write and no cmp_valid, and drops lane_run on the next edge.

Structure
REQ-028 A shared package holds the op_type encodings (VV/VX/VI), the cmp_err codes, the state encoding and the SEW decode constants; vec_alu uses the same package.
REQ-029 One sub-module, vec_bcast, is natural: a combinational SEW-replicator for VX/VI op1 (inputs 64-bit value and vsew, output VLEN).
REQ-030 The lanes are instantiated outside this block.

Verification
REQ-031 VV vand, vsew=0, v1=0xFF00..FF00, v2=0x0F0F..0F0F, lanes model 4-cycle done -> WB writes 0x0F00..0F00 to vd and cmp_valid pulses once with err 00.
REQ-032 VX, vsew=1, scalar=0x0001ABCD -> lane_vs1=0xABCD replicated 8 times.
REQ-033 VI, vsew=2, imm=5'b10000 -> lane_vs1=0xFFFFFFF0 replicated 4 times; lane_run first rises at T+4.
REQ-034 vsew=3'b101 -> cmp_err=01 at T+1, lane_run never rises, vrf_we stays 0.
REQ-035 One lane never asserts done, TIMEOUT=16 -> ERR after 16 RUN cycles with cmp_err=10 and no VRF write; the next request is accepted.
REQ-036 resetn low during RUN, then a new request -> no write or cmp_valid for the first instruction; the second completes correctly, with req_ready low throughout the busy period.
